// File: rtl/vga_controller.sv
// 640x480@60 Hz VGA raster generator: 25 MHz pixel tick from the 50 MHz clock,
// raster counters, and sync/blank outputs delayed to match the renderer latency.
module vga_controller #(
  parameter int PIPE_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic       vga_clk,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  logic       tick;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] frame_cnt;
  logic       h_wrap;
  logic       hs_raw;
  logic       vs_raw;
  logic       bl_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= ~tick;
  end

  assign pix_en  = tick;
  assign vga_clk = tick;
  assign h_wrap  = (h_cnt == H_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 8'd1;
  end

  assign hs_raw = ~in_window(h_cnt, H_SYNC_START, H_SYNC_END);
  assign vs_raw = ~in_window(v_cnt, V_SYNC_START, V_SYNC_END);
  assign bl_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE);

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign hsync   = hs_raw;
      assign vsync   = vs_raw;
      assign blank_n = bl_raw;
    end else begin : g_delay
      // stage 0 .. PIPE_DELAY-1: {hs, vs, bl}, inactive value 3'b110
      logic [2:0] dly_p [PIPE_DELAY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_p[i] <= 3'b110;
        end else if (tick) begin
          dly_p[0] <= {hs_raw, vs_raw, bl_raw};
          for (int i = 1; i < PIPE_DELAY; i++) dly_p[i] <= dly_p[i-1];
        end
      end

      assign {hsync, vsync, blank_n} = dly_p[PIPE_DELAY-1];
    end
  endgenerate

  assign sync_n      = 1'b0;
  assign x           = h_cnt;
  assign y           = v_cnt;
  assign frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: three instances (delay 0, 1, 4) against a raster
// scoreboard, plus table-driven timing probes and hand-written reset/wrap sequences.
module tb_vga_controller;

  localparam int DLY [3] = '{0, 1, 4};

  localparam int P_HSX0 = 0, P_HSX1 = 1, P_HSX4 = 2, P_HSW0 = 3, P_HSW1 = 4, P_HSW4 = 5;
  localparam int P_HSPER = 6, P_BLRX = 7, P_BLFX = 8, P_BLW = 9, P_VSFY = 10, P_VSFX = 11;
  localparam int P_VSW = 12, P_FSD = 13, P_FC = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic       pix_en_o  [3];
  logic       vga_clk_o [3];
  logic [9:0] x_o       [3];
  logic [9:0] y_o       [3];
  logic       hs_o      [3];
  logic       vs_o      [3];
  logic       bl_o      [3];
  logic       sn_o      [3];
  logic       fs_o      [3];
  logic [7:0] fc_o      [3];

  vga_controller #(.PIPE_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .pix_en(pix_en_o[0]), .vga_clk(vga_clk_o[0]), .x(x_o[0]), .y(y_o[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .blank_n(bl_o[0]), .sync_n(sn_o[0]),
    .frame_start(fs_o[0]), .frame_count(fc_o[0]));
  vga_controller #(.PIPE_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .pix_en(pix_en_o[1]), .vga_clk(vga_clk_o[1]), .x(x_o[1]), .y(y_o[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .blank_n(bl_o[1]), .sync_n(sn_o[1]),
    .frame_start(fs_o[1]), .frame_count(fc_o[1]));
  vga_controller #(.PIPE_DELAY(4)) dut4 (
    .clk(clk), .rst(rst), .pix_en(pix_en_o[2]), .vga_clk(vga_clk_o[2]), .x(x_o[2]), .y(y_o[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]), .blank_n(bl_o[2]), .sync_n(sn_o[2]),
    .frame_start(fs_o[2]), .frame_count(fc_o[2]));

  typedef struct {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic [7:0] fc;
    logic       fs;
    logic [2:0] hs;
    logic [2:0] vs;
    logic [2:0] bl;
    logic       sync_ok;
  } exp_t;

  typedef struct {
    string name;
    bit    jump;
    int    jh;
    int    jv;
    int    jfc;
    int    run;
    int    probe;
    int    exp;
  } vec_t;

  exp_t sb_q [$];
  int   errors = 0;
  int   checks = 0;

  // Reference raster model
  logic m_tick = 1'b0;
  int   m_h = 0, m_v = 0, m_fc = 0, skip = 0;
  int   jump_seq = 0, jump_seen = 0;
  int   req_h = 0, req_v = 0, req_fc = 0;

  function automatic logic [2:0] raster_sig(input int h, input int v, input int d);
    int p;
    int hh;
    int vv;
    p = v * 800 + h - d;
    if (p < 0) p = p + 420000;
    hh = p % 800;
    vv = p / 800;
    return {!(hh >= 656 && hh <= 751), !(vv >= 490 && vv <= 491), (hh < 640 && vv < 480)};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [2:0] sig;
    if (jump_seq != jump_seen) begin
      jump_seen = jump_seq;
      m_h = req_h;
      m_v = req_v;
      m_fc = req_fc;
      skip = 12;
    end
    if (rst) begin
      m_tick = 1'b0;
      m_h = 0;
      m_v = 0;
      m_fc = 0;
    end else begin
      if (m_tick) begin
        if (m_h == 0 && m_v == 0) m_fc = (m_fc + 1) % 256;
        if (m_h == 799) begin
          m_h = 0;
          m_v = (m_v == 524) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
      m_tick = !m_tick;
    end
    if (skip > 0) skip = skip - 1;
    e.tick = m_tick;
    e.h = m_h[9:0];
    e.v = m_v[9:0];
    e.fc = m_fc[7:0];
    e.fs = m_tick && m_h == 0 && m_v == 0;
    for (int i = 0; i < 3; i++) begin
      sig = raster_sig(m_h, m_v, DLY[i]);
      e.hs[i] = sig[2];
      e.vs[i] = sig[1];
      e.bl[i] = sig[0];
    end
    e.sync_ok = (skip == 0);
    sb_q.push_back(e);
  end

  // Edge/width monitors
  int   cyc = 0;
  logic hs_prev [3] = '{1'b1, 1'b1, 1'b1};
  int   hs_cnt [3] = '{0, 0, 0};
  int   hs_fx  [3] = '{-1, -1, -1};
  int   hs_w   [3] = '{-1, -1, -1};
  int   hs_fc  [3] = '{-1, -1, -1};
  int   hs_per [3] = '{-1, -1, -1};
  logic bl_prev = 1'b0;
  int   bl_cnt = 0, bl_rx = -1, bl_fx = -1, bl_w = -1;
  logic vs_prev = 1'b1;
  int   vs_cnt = 0, vs_fx = -1, vs_fy = -1, vs_w = -1;
  int   fs_total = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (hs_o[i] === 1'b0) begin
        if (hs_prev[i]) begin
          hs_fx[i] = int'(x_o[i]);
          if (hs_fc[i] >= 0) hs_per[i] = cyc - hs_fc[i];
          hs_fc[i] = cyc;
          hs_cnt[i] = 1;
        end else begin
          hs_cnt[i] = hs_cnt[i] + 1;
        end
      end else if (!hs_prev[i]) begin
        hs_w[i] = hs_cnt[i];
      end
      hs_prev[i] = (hs_o[i] !== 1'b0);
    end
    if (bl_o[1] === 1'b1) begin
      if (!bl_prev) begin
        bl_rx = int'(x_o[1]);
        bl_cnt = 1;
      end else begin
        bl_cnt = bl_cnt + 1;
      end
    end else if (bl_prev) begin
      bl_fx = int'(x_o[1]);
      bl_w = bl_cnt;
    end
    bl_prev = (bl_o[1] === 1'b1);
    if (vs_o[1] === 1'b0) begin
      if (vs_prev) begin
        vs_fx = int'(x_o[1]);
        vs_fy = int'(y_o[1]);
        vs_cnt = 1;
      end else begin
        vs_cnt = vs_cnt + 1;
      end
    end else if (!vs_prev) begin
      vs_w = vs_cnt;
    end
    vs_prev = (vs_o[1] !== 1'b0);
    if (fs_o[1] === 1'b1) fs_total = fs_total + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    logic [34:0] act;
    logic [34:0] expv;
    logic [34:0] mask;
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    if (errors >= 50) return;
    for (int i = 0; i < 3; i++) begin
      mask = e.sync_ok ? {35{1'b1}} : ~(35'h7 << 10);
      act  = {pix_en_o[i], vga_clk_o[i], x_o[i], y_o[i], hs_o[i], vs_o[i], bl_o[i],
              sn_o[i], fs_o[i], fc_o[i]};
      expv = {e.tick, e.tick, e.h, e.v, e.hs[i], e.vs[i], e.bl[i], 1'b0, e.fs, e.fc};
      checks = checks + 1;
      if (((act ^ expv) & mask) !== 35'd0) begin
        errors = errors + 1;
        $display("FAIL sb_dut%0d at %0t: got %h expected %h (mask %h)", i, $time, act, expv, mask);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_compare();
  endtask

  logic [9:0] f_h;
  logic [9:0] f_v;
  logic [7:0] f_fc;

  task do_jump(input int jh, input int jv, input int jfc);
    step();
    #2;
    f_h  = jh[9:0];
    f_v  = jv[9:0];
    f_fc = (jfc < 0) ? m_fc[7:0] : jfc[7:0];
    force dut0.h_cnt = f_h;
    force dut1.h_cnt = f_h;
    force dut4.h_cnt = f_h;
    force dut0.v_cnt = f_v;
    force dut1.v_cnt = f_v;
    force dut4.v_cnt = f_v;
    force dut0.frame_cnt = f_fc;
    force dut1.frame_cnt = f_fc;
    force dut4.frame_cnt = f_fc;
    req_h = jh;
    req_v = jv;
    req_fc = int'(f_fc);
    jump_seq = jump_seq + 1;
    #1;
    release dut0.h_cnt;
    release dut1.h_cnt;
    release dut4.h_cnt;
    release dut0.v_cnt;
    release dut1.v_cnt;
    release dut4.v_cnt;
    release dut0.frame_cnt;
    release dut1.frame_cnt;
    release dut4.frame_cnt;
  endtask

  function automatic int probe_val(input int p, input int fs_snap);
    case (p)
      P_HSX0:  return hs_fx[0];
      P_HSX1:  return hs_fx[1];
      P_HSX4:  return hs_fx[2];
      P_HSW0:  return hs_w[0];
      P_HSW1:  return hs_w[1];
      P_HSW4:  return hs_w[2];
      P_HSPER: return hs_per[1];
      P_BLRX:  return bl_rx;
      P_BLFX:  return bl_fx;
      P_BLW:   return bl_w;
      P_VSFY:  return vs_fy;
      P_VSFX:  return vs_fx;
      P_VSW:   return vs_w;
      P_FSD:   return fs_total - fs_snap;
      P_FC:    return int'(fc_o[1]);
      default: return -1;
    endcase
  endfunction

  vec_t tbl [15];

  initial begin
    int fs_snap;
    tbl[0]  = '{"hs_fall_x_d0",   1'b0,   0,   0,  -1, 3300, P_HSX0,  656};
    tbl[1]  = '{"hs_fall_x_d1",   1'b0,   0,   0,  -1,    0, P_HSX1,  657};
    tbl[2]  = '{"hs_fall_x_d4",   1'b0,   0,   0,  -1,    0, P_HSX4,  660};
    tbl[3]  = '{"hs_width_d0",    1'b0,   0,   0,  -1,    0, P_HSW0,  192};
    tbl[4]  = '{"hs_width_d1",    1'b0,   0,   0,  -1,    0, P_HSW1,  192};
    tbl[5]  = '{"hs_width_d4",    1'b0,   0,   0,  -1,    0, P_HSW4,  192};
    tbl[6]  = '{"line_period",    1'b0,   0,   0,  -1,    0, P_HSPER, 1600};
    tbl[7]  = '{"blank_rise_x",   1'b0,   0,   0,  -1,    0, P_BLRX,  1};
    tbl[8]  = '{"blank_fall_x",   1'b0,   0,   0,  -1,    0, P_BLFX,  641};
    tbl[9]  = '{"blank_width",    1'b0,   0,   0,  -1,    0, P_BLW,   1280};
    tbl[10] = '{"vs_fall_y",      1'b1, 700, 489,  -1, 3600, P_VSFY,  490};
    tbl[11] = '{"vs_fall_x",      1'b0,   0,   0,  -1,    0, P_VSFX,  1};
    tbl[12] = '{"vs_width",       1'b0,   0,   0,  -1,    0, P_VSW,   3200};
    tbl[13] = '{"frame_edge_fs",  1'b1, 797, 524,  -1,   20, P_FSD,   1};
    tbl[14] = '{"frame_count_2",  1'b0,   0,   0,  -1,    0, P_FC,    2};

    // Reset held for five clocks
    for (int k = 0; k < 5; k++) begin
      step();
      check("rst_x", int'(x_o[1]), 0);
      check("rst_y", int'(y_o[1]), 0);
      check("rst_hsync", int'(hs_o[1]), 1);
      check("rst_vsync", int'(vs_o[1]), 1);
      check("rst_blank_n", int'(bl_o[1]), 0);
      check("rst_pix_en", int'(pix_en_o[1]), 0);
    end
    #2 rst = 1'b0;
    step();
    check("post_pix_en", int'(pix_en_o[1]), 1);
    check("post_frame_start", int'(fs_o[1]), 1);
    check("post_frame_count0", int'(fc_o[1]), 0);
    step();
    check("post_frame_count1", int'(fc_o[1]), 1);
    check("post_x1", int'(x_o[1]), 1);

    for (int r = 0; r < 15; r++) begin
      fs_snap = fs_total;
      if (tbl[r].jump) do_jump(tbl[r].jh, tbl[r].jv, tbl[r].jfc);
      for (int c = 0; c < tbl[r].run; c++) step();
      check(tbl[r].name, probe_val(tbl[r].probe, fs_snap), tbl[r].exp);
    end

    // Frame counter wrap 255 -> 0 on the frame_start edge
    do_jump(797, 524, 255);
    for (int c = 0; c < 40 && fs_o[1] !== 1'b1; c++) step();
    check("wrap_fs_seen", int'(fs_o[1]), 1);
    check("wrap_fc_before", int'(fc_o[1]), 255);
    step();
    check("wrap_fc_after", int'(fc_o[1]), 0);

    // Reset in the middle of a frame
    do_jump(300, 200, -1);
    check("mid_x_before", int'(x_o[1]), 300);
    rst = 1'b1;
    #1;
    check("mid_rst_x", int'(x_o[1]), 0);
    check("mid_rst_y", int'(y_o[1]), 0);
    check("mid_rst_blank_n", int'(bl_o[1]), 0);
    step();
    #2 rst = 1'b0;
    step();
    check("mid_post_pix_en", int'(pix_en_o[1]), 1);
    check("mid_post_frame_start", int'(fs_o[1]), 1);
    step();
    check("mid_post_frame_count", int'(fc_o[1]), 1);
    check("mid_post_x", int'(x_o[1]), 1);
    for (int c = 0; c < 20; c++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
